// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data main-memory arbiter.
package mem_arb_pkg;

  localparam int BLOCK_WIDTH_DEF  = 128;
  localparam int ADDR_WIDTH_DEF   = 28;
  localparam int D_STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_checker.sv
// Simulation-time protocol checks on the data-cache request lines.
module mem_arb_checker (
  input logic clk,
  input logic rst_n,
  input logic d_read,
  input logic d_write
);

  // A D-cache must never ask for a read and a write-back at once; the write wins.
  illegal_rw: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
    else $error("mem_arbiter: D_MEM_READ and D_MEM_WRITE both high, servicing the write");

endmodule

// File: rtl/mem_arb_select.sv
// Priority decision for the arbiter: data side wins unless the instruction
// side has watched D_STREAK_MAX consecutive data grants go by.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int D_STREAK_MAX = D_STREAK_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_req,
  input  logic   d_req,
  input  state_e state,
  output logic   grant_i,
  output logic   grant_d
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          idle;
  logic          starved;

  // Grant decision and streak bookkeeping, evaluated only in IDLE.
  always_comb begin
    idle     = (state == ST_IDLE);
    starved  = (streak_q >= STREAK_MAX);
    grant_d  = idle & d_req & (~i_req | ~starved);
    grant_i  = idle & i_req & (~d_req | starved);
    streak_d = streak_q;
    if (grant_i) begin
      streak_d = '0;
    end else if (grant_d && i_req) begin
      streak_d = starved ? STREAK_MAX : streak_q + SW'(1);
    end else if (idle && !i_req) begin
      streak_d = '0;
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache and D-cache, serialising block
// transfers and giving each cache a private-memory style BUSYWAIT handshake.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WIDTH  = BLOCK_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int D_STREAK_MAX = D_STREAK_MAX_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_MEM_READ,
  input  logic [ADDR_WIDTH-1:0]  I_MEM_ADDR,
  output logic [BLOCK_WIDTH-1:0] I_MEM_READDATA,
  output logic                   I_MEM_BUSYWAIT,
  input  logic                   D_MEM_READ,
  input  logic                   D_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_MEM_ADDR,
  input  logic [BLOCK_WIDTH-1:0] D_MEM_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_MEM_READDATA,
  output logic                   D_MEM_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDR,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  logic                   first_q, first_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [BLOCK_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                   d_req;
  logic                   grant_i;
  logic                   grant_d;

  assign d_req = D_MEM_READ | D_MEM_WRITE;

  mem_arb_select #(
    .D_STREAK_MAX(D_STREAK_MAX)
  ) u_sel (
    .clk    (CLK),
    .rst_n  (RESET),
    .i_req  (I_MEM_READ),
    .d_req  (d_req),
    .state  (state_q),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  mem_arb_checker u_chk (
    .clk    (CLK),
    .rst_n  (RESET),
    .d_read (D_MEM_READ),
    .d_write(D_MEM_WRITE)
  );

  // Stall follows the request combinationally and opens only in the owner's RELEASE cycle.
  assign I_MEM_BUSYWAIT = I_MEM_READ & ~((state_q == ST_RELEASE) & (owner_q == OWN_I));
  assign D_MEM_BUSYWAIT = d_req & ~((state_q == ST_RELEASE) & (owner_q == OWN_D));

  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  assign MEM_ADDR       = mem_addr_q;
  assign MEM_WRITEDATA  = mem_wdata_q;
  assign I_MEM_READDATA = i_rdata_q;
  assign D_MEM_READDATA = d_rdata_q;

  // Transfer sequencing; MEM_BUSYWAIT is ignored in the grant entry cycle
  // because memory has not yet seen the new request.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    first_d     = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d     = ST_GRANT_D;
          owner_d     = OWN_D;
          first_d     = 1'b1;
          mem_write_d = D_MEM_WRITE;
          mem_read_d  = D_MEM_READ & ~D_MEM_WRITE;
          mem_addr_d  = D_MEM_ADDR;
          mem_wdata_d = D_MEM_WRITEDATA;
        end else if (grant_i) begin
          state_d     = ST_GRANT_I;
          owner_d     = OWN_I;
          first_d     = 1'b1;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = I_MEM_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (!first_q && !MEM_BUSYWAIT) begin
          if (mem_read_q && owner_q == OWN_I) begin
            i_rdata_d = MEM_READDATA;
          end else if (mem_read_q) begin
            d_rdata_d = MEM_READDATA;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_RELEASE;
        end else begin
          state_d = state_q;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      first_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory model plus
// hand-computed expectations for reset, single transfers, priority and starvation.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int BW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rd;
  logic [AW-1:0] i_addr;
  logic [BW-1:0] i_rdata;
  logic          i_busy;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [BW-1:0] d_wdata;
  logic [BW-1:0] d_rdata;
  logic          d_busy;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata;
  logic          mem_busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  int mem_lat = 0;
  int mem_cnt = 0;
  logic [AW-1:0] grant_log[$];
  logic prev_act = 1'b0;

  mem_arbiter dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .I_MEM_READ     (i_rd),
    .I_MEM_ADDR     (i_addr),
    .I_MEM_READDATA (i_rdata),
    .I_MEM_BUSYWAIT (i_busy),
    .D_MEM_READ     (d_rd),
    .D_MEM_WRITE    (d_wr),
    .D_MEM_ADDR     (d_addr),
    .D_MEM_WRITEDATA(d_wdata),
    .D_MEM_READDATA (d_rdata),
    .D_MEM_BUSYWAIT (d_busy),
    .MEM_READ       (mem_read),
    .MEM_WRITE      (mem_write),
    .MEM_ADDR       (mem_addr),
    .MEM_WRITEDATA  (mem_wdata),
    .MEM_READDATA   (mem_rdata),
    .MEM_BUSYWAIT   (mem_busy)
  );

  always #5 clk = ~clk;

  // Memory stays busy for mem_lat cycles of an access, then reports completion.
  assign mem_busy = (mem_read | mem_write) && (mem_cnt < mem_lat);

  initial forever begin
    @(posedge clk);
    mem_cnt <= (mem_read === 1'b1 || mem_write === 1'b1) ? mem_cnt + 1 : 0;
  end

  // Log the address of every new grant to recover grant order.
  initial forever begin
    @(posedge clk);
    #2;
    if ((mem_read === 1'b1 || mem_write === 1'b1) && prev_act !== 1'b1)
      grant_log.push_back(mem_addr);
    prev_act = (mem_read === 1'b1 || mem_write === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    int rd_cycles;
    int wr_cycles;
    int fall;
    int bad;
    logic [AW-1:0] exp_order[7];
    exp_order = '{28'h20, 28'h20, 28'h20, 28'h20, 28'h10, 28'h20, 28'h20};

    // Reset with both caches requesting.
    rst_n = 1'b0; i_rd = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
    i_addr = 28'h10; d_addr = 28'h30; d_wdata = '0;
    mem_lat = 2; mem_rdata = {4{32'h11111111}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_read", mem_read, 1'b0);
    check_val("rst_mem_write", mem_write, 1'b0);
    check_val("rst_mem_addr", mem_addr, 28'h0);
    check_val("rst_mem_wdata", mem_wdata, '0);
    check_val("rst_i_rdata", i_rdata, '0);
    check_val("rst_d_rdata", d_rdata, '0);
    check_val("rst_state", dut.state_q, ST_IDLE);
    check_val("rst_i_busy", i_busy, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_d_first", mem_read, 1'b1);
    check_val("post_rst_d_addr", mem_addr, 28'h30);
    i_rd = 1'b0; d_rd = 1'b0;
    repeat (8) @(negedge clk);
    check_val("withdrawn_d_rdata", d_rdata, {4{32'h11111111}});
    check_val("withdrawn_i_rdata", i_rdata, '0);
    check_val("withdrawn_idle", mem_read, 1'b0);

    // Lone I read, memory busy 5 cycles.
    mem_lat = 5; mem_rdata = 128'hDEADBEEF_00000001_00000002_00000003;
    i_addr = 28'h10; i_rd = 1'b1;
    #1;
    check_val("i_busy_same_cycle", i_busy, 1'b1);
    rd_cycles = 0; fall = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_read) rd_cycles++;
      if (k == 1) check_val("i_mem_addr", mem_addr, 28'h10);
      if (!i_busy && fall == 0) begin
        fall = k;
        i_rd = 1'b0;
      end
    end
    check_val("i_read_cycles", rd_cycles, 6);
    check_val("i_busy_fall", fall, 7);
    check_val("i_rdata", i_rdata, 128'hDEADBEEF_00000001_00000002_00000003);

    // D write-back; inputs change after grant to show capture.
    mem_lat = 3; mem_rdata = {4{32'h77777777}};
    d_addr = 28'h20; d_wdata = {16{8'hA5}}; d_wr = 1'b1;
    wr_cycles = 0; rd_cycles = 0; fall = 0; bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_read) rd_cycles++;
      if (mem_write) begin
        wr_cycles++;
        if (mem_addr !== 28'h20 || mem_wdata !== {16{8'hA5}}) bad++;
      end
      if (k == 1) begin
        d_addr = 28'h99; d_wdata = '0;
      end
      if (!d_busy && d_wr && fall == 0) begin
        fall = k;
        d_wr = 1'b0;
      end
    end
    check_val("d_write_cycles", wr_cycles, 4);
    check_val("d_write_held", bad, 0);
    check_val("d_write_no_read", rd_cycles, 0);
    check_val("d_busy_fall", fall, 5);
    check_val("d_rdata_unchanged", d_rdata, {4{32'h11111111}});

    // Simultaneous requests: D first, I next, I stalled throughout D.
    grant_log.delete();
    mem_lat = 2; mem_rdata = {4{32'hCAFEF00D}};
    i_addr = 28'h10; d_addr = 28'h20; d_wdata = {16{8'hA5}};
    i_rd = 1'b1; d_wr = 1'b1; bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_write && !i_busy) bad++;
      if (d_wr && !d_busy) d_wr = 1'b0;
      if (i_rd && !i_busy) i_rd = 1'b0;
      if (!d_wr && !i_rd) break;
    end
    repeat (3) @(negedge clk);
    check_val("simul_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_val("simul_first_d", grant_log[0], 28'h20);
      check_val("simul_then_i", grant_log[1], 28'h10);
    end
    check_val("simul_i_stalled", bad, 0);
    check_val("simul_i_rdata", i_rdata, {4{32'hCAFEF00D}});

    // Starvation bound: I held high against continuous D write-backs.
    grant_log.delete();
    mem_lat = 1;
    i_rd = 1'b1; d_wr = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (grant_log.size() >= 7) break;
    end
    i_rd = 1'b0; d_wr = 1'b0;
    repeat (8) @(negedge clk);
    check_val("starve_grants", grant_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < grant_log.size()) check_val($sformatf("starve_order%0d", i), grant_log[i], exp_order[i]);
    end

    // Reset two cycles into a D grant, with I pending so the streak is non-zero.
    mem_lat = 8;
    d_addr = 28'h40; d_wdata = {16{8'h5A}};
    i_rd = 1'b1; d_wr = 1'b1;
    @(negedge clk);
    check_val("mid_grant_d", mem_write, 1'b1);
    check_val("mid_streak_one", dut.u_sel.streak_q, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_write", mem_write, 1'b0);
    check_val("mid_rst_addr", mem_addr, 28'h0);
    check_val("mid_rst_wdata", mem_wdata, '0);
    check_val("mid_rst_state", dut.state_q, ST_IDLE);
    check_val("mid_rst_streak", dut.u_sel.streak_q, 0);
    check_val("mid_rst_d_busy", d_busy, 1'b1);
    rst_n = 1'b1; i_rd = 1'b0;
    @(negedge clk);
    check_val("regrant_write", mem_write, 1'b1);
    check_val("regrant_addr", mem_addr, 28'h40);
    check_val("regrant_wdata", mem_wdata, {16{8'h5A}});
    fall = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!d_busy && d_wr) begin
        fall = k;
        d_wr = 1'b0;
      end
    end
    check_val("regrant_fall", fall, 9);
    check_val("regrant_done", mem_write, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between instruction-cache misses and data-cache misses/write-backs.
- Sits between both caches and the main memory model.
- Serialises block transfers and applies data-side priority with a starvation bound for the instruction side.
- Presents each cache the same BUSYWAIT-style handshake it would see from a private memory.

Parameters:
- BLOCK_WIDTH, 128, bits per memory block transfer.
- ADDR_WIDTH, 28, block address width (byte address without the 4 offset bits).
- D_STREAK_MAX, 4, maximum consecutive data grants while an instruction request is pending.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset; sampled on the posedge of CLK.
- I_MEM_READ  in  1  I-cache block read request; held until its BUSYWAIT drops.
- I_MEM_ADDR  in  ADDR_WIDTH  I-cache block address.
- I_MEM_READDATA  out  BLOCK_WIDTH  block returned to I-cache.
- I_MEM_BUSYWAIT  out  1  I-cache stall.
- D_MEM_READ  in  1  D-cache block read request.
- D_MEM_WRITE  in  1  D-cache block write-back request.
- D_MEM_ADDR  in  ADDR_WIDTH  D-cache block address.
- D_MEM_WRITEDATA  in  BLOCK_WIDTH  write-back block.
- D_MEM_READDATA  out  BLOCK_WIDTH  block returned to D-cache.
- D_MEM_BUSYWAIT  out  1  D-cache stall.
- MEM_READ  out  1  main-memory read.
- MEM_WRITE  out  1  main-memory write.
- MEM_ADDR  out  ADDR_WIDTH  main-memory block address.
- MEM_WRITEDATA  out  BLOCK_WIDTH  main-memory write data.
- MEM_READDATA  in  BLOCK_WIDTH  main-memory read data.
- MEM_BUSYWAIT  in  1  main memory busy; low means the current access is complete.

Behaviour:
- States: IDLE, GRANT_I, GRANT_D, RELEASE. Owner register is I or D.
- Reset (RESET low at posedge): state IDLE; MEM_READ=MEM_WRITE=0; MEM_ADDR=0; MEM_WRITEDATA=0; both READDATA=0; streak counter=0.
- Reset mid-transfer: the memory access is abandoned; the caches must re-request.
- Arbitration in IDLE, one decision per cycle:
  - D request only -> GRANT_D.
  - I request only -> GRANT_I.
  - Both, streak < D_STREAK_MAX -> GRANT_D.
  - Both, streak == D_STREAK_MAX -> GRANT_I.
- Streak counter:
  - Increments on each GRANT_D entry while I_MEM_READ is high; saturates at D_STREAK_MAX.
  - Clears on GRANT_I entry.
  - Clears in IDLE when I_MEM_READ is low.
- Entering a grant state, MEM_* are registered outputs driven from the owner's inputs:
  - GRANT_I: MEM_READ=1.
  - GRANT_D: MEM_WRITE=D_MEM_WRITE, MEM_READ=D_MEM_READ & ~D_MEM_WRITE.
  - Address and write data are captured at grant and held constant through the grant.
- Completion: in a grant state, the first posedge after the entry cycle with MEM_BUSYWAIT=0 ends the access.
  - On a read, MEM_READDATA is latched into the owner's READDATA.
  - MEM_READ/WRITE drop to 0; next state RELEASE.
- RELEASE lasts exactly 1 cycle and gives the cache time to drop its request. Next state is IDLE; no arbitration in RELEASE.
- BUSYWAIT (combinational): X_MEM_BUSYWAIT = X request & ~(state==RELEASE & owner==X). It is high in the same cycle the request rises.
- Latency with memory busy for L cycles after grant: request at cycle N -> grant N+1 -> complete N+1+L -> RELEASE N+2+L with BUSYWAIT=0 -> IDLE N+3+L.
- READDATA holds its value until the next read completion for that owner.
- Request withdrawn during a grant: the access still completes; read data is latched; BUSYWAIT is already 0.
- D_MEM_READ and D_MEM_WRITE both high: illegal. The write is serviced; a simulation-only error message is issued.
- An I request arriving in the same cycle D completes waits until IDLE; it is never dropped.
- No back-to-back grants: minimum 1 IDLE cycle between transfers.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE, GRANT_I, GRANT_D, RELEASE);
  - owner encoding;
  - default BLOCK_WIDTH and ADDR_WIDTH constants.
- One sub-module, mem_arb_select: combinational priority decision plus the streak counter register. Inputs: requests, state. Outputs: grant_i, grant_d.

Test Plan:
- Reset: RESET=0 for 2 cycles with both requests high -> all MEM_* 0, both READDATA 0, state IDLE; after RESET=1, D granted first.
- Lone I read: I_MEM_ADDR=0x0000010, memory busy 5 cycles returning 0xDEADBEEF_00000001_00000002_00000003 -> MEM_READ high for 6 cycles, I_MEM_READDATA equals that block, I_MEM_BUSYWAIT falls exactly in RELEASE (cycle N+7).
- D write-back: D_MEM_WRITE=1, addr 0x0000020, data 0xA5A5…A5 -> MEM_WRITE=1, MEM_ADDR=0x0000020, MEM_WRITEDATA=0xA5A5…A5 held constant through the grant; D_MEM_READDATA unchanged.
- Simultaneous: I and D request in the same cycle -> D served first; I served in the next grant; I_MEM_BUSYWAIT stays high throughout D's transfer.
- Starvation: I held high while D issues 6 back-to-back requests, D_STREAK_MAX=4 -> grant order D,D,D,D,I,D,D.
- Reset mid-transfer: RESET low 2 cycles into GRANT_D -> next posedge MEM_WRITE=0, state IDLE, streak=0; the D re-request is granted normally.
